// File: rtl/lcd_wb_sram_loader.sv
// Wishbone initiator that drains an 8-bit byte stream through a small FIFO into
// the LCD controller SRAM window, one single write cycle per byte at incrementing addresses.
module lcd_wb_sram_loader #(
    parameter int ADDRWIDTH   = 11,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RSTn_i,
    input  logic                 Start_i,
    input  logic [ADDRWIDTH-1:0] Start_Adr_i,
    input  logic [ADDRWIDTH:0]   Byte_Cnt_i,
    input  logic                 Abort_i,
    input  logic [7:0]           Strm_DAT_i,
    input  logic                 Strm_VLD_i,
    output logic                 Strm_RDY_o,
    output logic                 Busy_o,
    output logic                 Done_o,
    output logic                 Err_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [31:0]          WBm_DAT_o,
    input  logic                 WBm_ACK_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RUN, BUS, GAP, FLUSH} state_t;

    state_t               state_reg;
    logic [ADDRWIDTH-1:0] addr_reg;
    logic [ADDRWIDTH:0]   remaining_reg;
    logic [ADDRWIDTH:0]   accepted_reg;
    logic [ADDRWIDTH:0]   byte_cnt_reg;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [PW:0]          wr_ptr_reg;
    logic [PW:0]          rd_ptr_reg;
    logic [TW-1:0]        tmo_reg;
    logic                 abort_pend_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic                 cyc_reg;
    logic                 stb_reg;
    logic                 we_reg;
    logic [3:0]           byte_stb_reg;
    logic [ADDRWIDTH-1:0] adr_reg;
    logic [31:0]          dat_reg;

    logic fifo_empty;
    logic fifo_full;
    logic stop_req;
    logic rdy;
    logic push;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) &&
                        (wr_ptr_reg[PW] != rd_ptr_reg[PW]);
    assign stop_req   = abort_pend_reg | Abort_i;
    assign rdy        = busy_reg && (state_reg != FLUSH) && !fifo_full &&
                        (accepted_reg < byte_cnt_reg) && !abort_pend_reg;
    assign push       = Strm_VLD_i && rdy;

    always_ff @(posedge WBs_CLK_i) begin
        if (push) begin
            mem[wr_ptr_reg[PW-1:0]] <= Strm_DAT_i;
        end
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
        if (!WBs_RSTn_i) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            remaining_reg  <= '0;
            accepted_reg   <= '0;
            byte_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            tmo_reg        <= '0;
            abort_pend_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cyc_reg        <= 1'b0;
            stb_reg        <= 1'b0;
            we_reg         <= 1'b0;
            byte_stb_reg   <= '0;
            adr_reg        <= '0;
            dat_reg        <= '0;
        end else begin
            done_reg <= 1'b0;
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                accepted_reg <= accepted_reg + 1'b1;
            end
            if (busy_reg && Abort_i) begin
                abort_pend_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (Start_i) begin
                        err_reg        <= 1'b0;
                        abort_pend_reg <= 1'b0;
                        if (Byte_Cnt_i != '0) begin
                            addr_reg      <= Start_Adr_i;
                            remaining_reg <= Byte_Cnt_i;
                            byte_cnt_reg  <= Byte_Cnt_i;
                            accepted_reg  <= '0;
                            busy_reg      <= 1'b1;
                            state_reg     <= RUN;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort is honoured only at a transaction boundary, i.e. here.
                    if (stop_req) begin
                        state_reg <= FLUSH;
                    end else if (!fifo_empty) begin
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        adr_reg      <= addr_reg;
                        dat_reg      <= {24'h0, mem[rd_ptr_reg[PW-1:0]]};
                        byte_stb_reg <= 4'b0001;
                        cyc_reg      <= 1'b1;
                        stb_reg      <= 1'b1;
                        we_reg       <= 1'b1;
                        tmo_reg      <= '0;
                        state_reg    <= BUS;
                    end
                end
                BUS: begin
                    // ACK is checked first so an ACK on the limit cycle still succeeds.
                    if (WBm_ACK_i) begin
                        cyc_reg       <= 1'b0;
                        stb_reg       <= 1'b0;
                        we_reg        <= 1'b0;
                        byte_stb_reg  <= '0;
                        addr_reg      <= addr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        state_reg     <= stop_req ? FLUSH : GAP;
                    end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
                        cyc_reg      <= 1'b0;
                        stb_reg      <= 1'b0;
                        we_reg       <= 1'b0;
                        byte_stb_reg <= '0;
                        err_reg      <= 1'b1;
                        state_reg    <= FLUSH;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (remaining_reg == '0) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                FLUSH: begin
                    wr_ptr_reg     <= '0;
                    rd_ptr_reg     <= '0;
                    busy_reg       <= 1'b0;
                    abort_pend_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Strm_RDY_o     = rdy;
    assign Busy_o         = busy_reg;
    assign Done_o         = done_reg;
    assign Err_o          = err_reg;
    assign WBm_ADR_o      = adr_reg;
    assign WBm_CYC_o      = cyc_reg;
    assign WBm_STB_o      = stb_reg;
    assign WBm_WE_o       = we_reg;
    assign WBm_BYTE_STB_o = byte_stb_reg;
    assign WBm_DAT_o      = dat_reg;
endmodule

// File: tb/tb_lcd_wb_sram_loader.sv
// Bench for lcd_wb_sram_loader: stream driver, Wishbone responder with programmable
// ACK delay, and a write-list model checked against the observed bus writes.
module tb_lcd_wb_sram_loader;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          vld = 1'b0;
    logic          ack = 1'b0;
    logic [AW-1:0] start_adr = '0;
    logic [AW:0]   byte_cnt = '0;
    logic [7:0]    sdat = '0;
    logic          rdy, busy, done, err, cyc, stb, we;
    logic [AW-1:0] adr;
    logic [3:0]    bs;
    logic [31:0]   dat;

    lcd_wb_sram_loader #(.ADDRWIDTH(AW), .FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut (
        .WBs_CLK_i(clk), .WBs_RSTn_i(rst_n), .Start_i(start), .Start_Adr_i(start_adr),
        .Byte_Cnt_i(byte_cnt), .Abort_i(abort), .Strm_DAT_i(sdat), .Strm_VLD_i(vld),
        .Strm_RDY_o(rdy), .Busy_o(busy), .Done_o(done), .Err_o(err),
        .WBm_ADR_o(adr), .WBm_CYC_o(cyc), .WBm_STB_o(stb), .WBm_WE_o(we),
        .WBm_BYTE_STB_o(bs), .WBm_DAT_o(dat), .WBm_ACK_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          cyc;
        logic [3:0]    bs;
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    int n_checks = 0, n_fail = 0;
    int ack_delay = 1, ack_cnt = 0;
    int cyc_idx = 0, done_cnt = 0, stb_high = 0, cyc_high = 0;
    int pushes = 0, exp_cnt = 0, occ_max = 0, rdy_viol = 0;
    logic stb_prev = 1'b0;
    wr_t  wr_q[$];
    int   rise_q[$];
    logic [7:0] tx_q[$];

    // Bus monitor and responder: ACK after ack_delay sampled STB cycles (0 = never).
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            cyc_idx++;
            if (done) done_cnt++;
            if (stb) stb_high++;
            if (cyc) cyc_high++;
            if (stb && !stb_prev) rise_q.push_back(cyc_idx);
            stb_prev = stb;
            if (ack) begin
                ack = 1'b0;
                ack_cnt = 0;
            end else if (stb && ack_delay > 0) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    ack = 1'b1;
                    ack_cnt = 0;
                    wr_q.push_back({we, cyc, bs, adr, dat});
                    $display("wr adr=%h dat=%h bs=%b", adr, dat, bs);
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Ready must be low whenever the model says the FIFO is full or the count is met.
    initial begin : rdy_mon
        int occ;
        forever begin
            @(negedge clk);
            occ = pushes - rise_q.size();
            if (occ > occ_max) occ_max = occ;
            if ((occ >= 4 || pushes >= exp_cnt) && rdy) rdy_viol++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_q.delete(); rise_q.delete();
        done_cnt = 0; stb_high = 0; cyc_high = 0; pushes = 0; occ_max = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input int n);
        start_adr = a; byte_cnt = n[AW:0]; exp_cnt = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic fill_tx(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic send_stream(input int budget, input bit must_finish);
        for (int i = 0; i < tx_q.size(); i++) begin
            bit sent;
            sent = 1'b0;
            sdat = tx_q[i];
            vld = 1'b1;
            for (int c = 0; c < budget && !sent; c++) begin
                @(negedge clk); sent = rdy;
                @(posedge clk); #1;
            end
            if (!sent) begin
                vld = 1'b0;
                if (must_finish) begin
                    n_checks++; n_fail++;
                    $display("FAIL stream_stall: byte %0d not accepted, required within %0d cycles", i, budget);
                end
                return;
            end
            pushes++;
        end
        vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && busy; c++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b required 0 within %0d cycles", busy, budget);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({rdy, busy, done, err, cyc, stb, we, bs, adr, dat} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {rdy, busy, done, err, cyc, stb, we, bs, adr, dat});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rdy, busy, done, err, cyc, stb} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b required 000000", {rdy, busy, done, err, cyc, stb});
        end
    endtask

    task automatic test_burst();
        logic [AW-1:0] a;
        a = 11'h1FE;
        clear_mon(); ack_delay = 1;
        tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_start(a, 4);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b required 1", busy); end
        send_stream(200, 1'b1);
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL burst_rdy_after_last: got %b required 0", rdy); end
        @(posedge clk); #1;
        wait_idle(100);
        n_checks++;
        if (wr_q.size() != 4) begin n_fail++; $display("FAIL burst_count: got %0d required 4", wr_q.size()); end
        for (int i = 0; i < tx_q.size() && i < wr_q.size(); i++) begin
            wr_t e;
            e = {1'b1, 1'b1, 4'b0001, AW'((int'(a) + i) % (1 << AW)), {24'h0, tx_q[i]}};
            n_checks++;
            if (wr_q[i] !== e) begin n_fail++; $display("FAIL burst_write_%0d: got %h required %h", i, wr_q[i], e); end
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            n_checks++;
            if (rise_q[i] - rise_q[i-1] != 3) begin
                n_fail++; $display("FAIL burst_spacing_%0d: got %0d cycles required 3", i, rise_q[i] - rise_q[i-1]);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL burst_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_addr_wrap();
        clear_mon(); ack_delay = 1; fill_tx(2);
        do_start(11'h7FF, 2);
        send_stream(200, 1'b1);
        wait_idle(100);
        n_checks++;
        if (wr_q.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d required 2", wr_q.size()); end
        else begin
            n_checks++;
            if (wr_q[0].adr !== 11'h7FF || wr_q[1].adr !== 11'h000) begin
                n_fail++; $display("FAIL wrap_addr: got %h,%h required 7ff,000", wr_q[0].adr, wr_q[1].adr);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL wrap_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_zero_count();
        clear_mon(); ack_delay = 1;
        do_start(AW'($urandom), 0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done_next: got done=%b busy=%b required 1,0", done, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b required 0", done); end
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (cyc_high != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_no_bus: got cyc_cycles=%0d done=%0d required 0,1", cyc_high, done_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_mon(); ack_delay = 0; fill_tx(3);
        do_start(AW'($urandom), 3);
        send_stream(200, 1'b1);
        wait_idle(100);
        n_checks++;
        if (stb_high != 15 || rise_q.size() != 1) begin
            n_fail++; $display("FAIL timeout_stb: got %0d cycles %0d strobes required 15,1", stb_high, rise_q.size());
        end
        n_checks++;
        if ({err, cyc, stb, busy} !== 4'b1000 || done_cnt != 0) begin
            n_fail++; $display("FAIL timeout_flags: got err,cyc,stb,busy=%b done=%0d required 1000,0", {err, cyc, stb, busy}, done_cnt);
        end
        ack_delay = 1;
        do_start(AW'($urandom), 0);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b required 0", err); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_back_pressure();
        logic [AW-1:0] a;
        a = AW'($urandom);
        clear_mon(); ack_delay = 5; fill_tx(8);
        do_start(a, 8);
        send_stream(200, 1'b1);
        wait_idle(300);
        n_checks++;
        if (occ_max != 4) begin n_fail++; $display("FAIL bp_fifo_fill: got max occupancy %0d required 4", occ_max); end
        n_checks++;
        if (wr_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d required 8", wr_q.size()); end
        for (int i = 0; i < tx_q.size() && i < wr_q.size(); i++) begin
            wr_t e;
            e = {1'b1, 1'b1, 4'b0001, AW'((int'(a) + i) % (1 << AW)), {24'h0, tx_q[i]}};
            n_checks++;
            if (wr_q[i] !== e) begin n_fail++; $display("FAIL bp_write_%0d: got %h required %h", i, wr_q[i], e); end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_bus();
        clear_mon(); ack_delay = 0; fill_tx(2);
        do_start(AW'($urandom), 2);
        send_stream(50, 1'b1);
        for (int c = 0; c < 20 && !stb; c++) begin @(posedge clk); #1; end
        n_checks++;
        if (stb !== 1'b1) begin n_fail++; $display("FAIL rst_bus_reached: got stb=%b required 1", stb); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cyc, stb, busy} !== 3'b000) begin
            n_fail++; $display("FAIL rst_async_drop: got cyc,stb,busy=%b required 000", {cyc, stb, busy});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon(); ack_delay = 1; fill_tx(1);
        do_start(AW'($urandom), 1);
        send_stream(50, 1'b1);
        wait_idle(100);
        n_checks++;
        if (wr_q.size() != 1 || done_cnt != 1) begin
            n_fail++; $display("FAIL rst_recover: got writes=%0d done=%0d required 1,1", wr_q.size(), done_cnt);
        end else begin
            n_checks++;
            if (wr_q[0].dat !== {24'h0, tx_q[0]}) begin
                n_fail++; $display("FAIL rst_recover_data: got %h required %h", wr_q[0].dat, {24'h0, tx_q[0]});
            end
        end
    endtask

    task automatic test_abort();
        clear_mon(); ack_delay = 4; fill_tx(4);
        do_start(AW'($urandom), 4);
        fork
            send_stream(30, 1'b0);
            begin
                for (int c = 0; c < 50 && !stb; c++) begin @(posedge clk); #1; end
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
        join
        wait_idle(100);
        n_checks++;
        if (wr_q.size() != 1) begin n_fail++; $display("FAIL abort_writes: got %0d required 1", wr_q.size()); end
        else begin
            n_checks++;
            if (wr_q[0].dat !== {24'h0, tx_q[0]}) begin
                n_fail++; $display("FAIL abort_data: got %h required %h", wr_q[0].dat, {24'h0, tx_q[0]});
            end
        end
        n_checks++;
        if (done_cnt != 0 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: got done=%0d err=%b busy=%b required 0,0,0", done_cnt, err, busy);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            logic [AW-1:0] a;
            int n;
            a = AW'($urandom);
            n = $urandom_range(1, 6);
            clear_mon(); ack_delay = $urandom_range(1, 3); fill_tx(n);
            do_start(a, n);
            send_stream(200, 1'b1);
            wait_idle(200);
            n_checks++;
            if (wr_q.size() != n || done_cnt != 1) begin
                n_fail++; $display("FAIL rand%0d_count: got writes=%0d done=%0d required %0d,1", t, wr_q.size(), done_cnt, n);
            end
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                wr_t e;
                e = {1'b1, 1'b1, 4'b0001, AW'((int'(a) + i) % (1 << AW)), {24'h0, tx_q[i]}};
                n_checks++;
                if (wr_q[i] !== e) begin n_fail++; $display("FAIL rand%0d_write_%0d: got %h required %h", t, i, wr_q[i], e); end
            end
        end
        n_checks++;
        if (rdy_viol != 0) begin n_fail++; $display("FAIL rdy_model: got %0d ready violations required 0", rdy_viol); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_addr_wrap();
        test_zero_count();
        test_timeout();
        test_back_pressure();
        test_reset_mid_bus();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
